// File: rtl/scan_rx.sv
// LED panel scan receiver: deserialises per-lane R/G/B rows,
// captures them on latch and tags them with matrix/row.
module scan_rx #(
  parameter int MATRIX_NUM  = 4,
  parameter int MATRIX_SIZE = 8,
  parameter int EN_TIMEOUT  = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          col_shift_clk_i,
  input  logic                          led_latch_i,
  input  logic                          led_en_i,
  input  logic [4:0]                    led_sel_i,
  input  logic [MATRIX_NUM-1:0]         led_r_i,
  input  logic [MATRIX_NUM-1:0]         led_g_i,
  input  logic [MATRIX_NUM-1:0]         led_b_i,
  output logic                          row_valid_o,
  output logic [1:0]                    row_matrix_o,
  output logic [2:0]                    row_idx_o,
  output logic [MATRIX_NUM*2*MATRIX_SIZE-1:0] row_r_o,
  output logic [MATRIX_NUM*2*MATRIX_SIZE-1:0] row_g_o,
  output logic [MATRIX_NUM*2*MATRIX_SIZE-1:0] row_b_o,
  output logic                          len_err_o,
  output logic                          timeout_err_o,
  output logic                          frame_done_o
);

  localparam int ROW_W = 2 * MATRIX_SIZE;
  localparam int LW    = MATRIX_NUM * ROW_W;
  localparam int CW    = $clog2(ROW_W + 2);
  localparam int TW    = $clog2(EN_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_SHIFT,
    S_WAIT_EN,
    S_EMIT
  } state_t;

  state_t state, state_nxt;

  logic          sclk_q, lat_q;
  logic          sclk_rise, lat_rise;
  logic [LW-1:0] sr_r, sr_g, sr_b;
  logic [LW-1:0] sr_r_nxt, sr_g_nxt, sr_b_nxt;
  logic [LW-1:0] sh_r, sh_g, sh_b;
  logic [CW-1:0] bit_cnt, cnt_nxt;
  logic [TW-1:0] tmo;
  logic          do_shift, do_lat;
  logic          emit, tmo_hit, len_bad, last_row;

  assign sclk_rise = col_shift_clk_i & ~sclk_q;
  assign lat_rise  = led_latch_i & ~lat_q;
  assign do_shift  = (state == S_SHIFT) & sclk_rise;
  assign do_lat    = (state == S_SHIFT) & lat_rise;

  // A bit arriving with the latch is shifted first so it joins the capture.
  always_comb begin
    sr_r_nxt = sr_r;
    sr_g_nxt = sr_g;
    sr_b_nxt = sr_b;
    cnt_nxt  = bit_cnt;
    if (do_shift) begin
      for (int m = 0; m < MATRIX_NUM; m++) begin
        sr_r_nxt[m*ROW_W +: ROW_W] =
          {led_r_i[m], sr_r[m*ROW_W+1 +: ROW_W-1]};
        sr_g_nxt[m*ROW_W +: ROW_W] =
          {led_g_i[m], sr_g[m*ROW_W+1 +: ROW_W-1]};
        sr_b_nxt[m*ROW_W +: ROW_W] =
          {led_b_i[m], sr_b[m*ROW_W+1 +: ROW_W-1]};
      end
      if (bit_cnt != CW'(ROW_W + 1))
        cnt_nxt = bit_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_SHIFT:   if (lat_rise) state_nxt = S_WAIT_EN;
      S_WAIT_EN: begin
        if (!led_en_i)
          state_nxt = S_EMIT;
        else if (tmo == TW'(1))
          state_nxt = S_SHIFT;
      end
      S_EMIT:    state_nxt = S_SHIFT;
      default:   state_nxt = S_SHIFT;
    endcase
  end

  always_comb begin
    emit     = (state == S_WAIT_EN) & ~led_en_i;
    tmo_hit  = (state == S_WAIT_EN) & led_en_i & (tmo == TW'(1));
    len_bad  = do_lat & (cnt_nxt != CW'(ROW_W));
    last_row = (led_sel_i[4:3] == 2'(MATRIX_NUM - 1)) &
               (led_sel_i[2:0] == 3'(MATRIX_SIZE - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_SHIFT;
      sclk_q        <= 1'b0;
      lat_q         <= 1'b0;
      sr_r          <= '0;
      sr_g          <= '0;
      sr_b          <= '0;
      sh_r          <= '0;
      sh_g          <= '0;
      sh_b          <= '0;
      bit_cnt       <= '0;
      tmo           <= '0;
      row_valid_o   <= 1'b0;
      row_matrix_o  <= '0;
      row_idx_o     <= '0;
      row_r_o       <= '0;
      row_g_o       <= '0;
      row_b_o       <= '0;
      len_err_o     <= 1'b0;
      timeout_err_o <= 1'b0;
      frame_done_o  <= 1'b0;
    end else begin
      state         <= state_nxt;
      sclk_q        <= col_shift_clk_i;
      lat_q         <= led_latch_i;
      sr_r          <= sr_r_nxt;
      sr_g          <= sr_g_nxt;
      sr_b          <= sr_b_nxt;
      bit_cnt       <= do_lat ? '0 : cnt_nxt;
      len_err_o     <= len_bad;
      timeout_err_o <= tmo_hit;
      row_valid_o   <= emit;
      frame_done_o  <= emit & last_row;
      if (do_lat) begin
        sh_r <= sr_r_nxt;
        sh_g <= sr_g_nxt;
        sh_b <= sr_b_nxt;
        tmo  <= TW'(EN_TIMEOUT);
      end else if ((state == S_WAIT_EN) & led_en_i) begin
        tmo <= tmo - 1'b1;
      end
      if (tmo_hit) begin
        sh_r <= '0;
        sh_g <= '0;
        sh_b <= '0;
      end
      if (emit) begin
        row_r_o      <= sh_r;
        row_g_o      <= sh_g;
        row_b_o      <= sh_b;
        row_matrix_o <= led_sel_i[4:3];
        row_idx_o    <= led_sel_i[2:0];
      end
    end
  end

endmodule

// File: tb/tb_scan_rx.sv
// Directed bench for scan_rx: row capture, length/timeout
// errors, full frame, coincident latch and mid-row reset.
module tb_scan_rx;

  logic        clk = 1'b0;
  logic        rst, sclk, lat, en;
  logic [4:0]  sel;
  logic [3:0]  r, g, b;
  logic        row_valid, len_err, tmo_err, frame_done;
  logic [1:0]  row_matrix;
  logic [2:0]  row_idx;
  logic [63:0] row_r, row_g, row_b;

  logic [15:0] vr[4], vg[4], vb[4];

  int n_tests = 0;
  int n_fail  = 0;
  int rv_cnt  = 0;
  int le_cnt  = 0;
  int to_cnt  = 0;
  int fd_cnt  = 0;
  logic [4:0] fd_sel = '0;

  scan_rx dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .col_shift_clk_i (sclk),
    .led_latch_i     (lat),
    .led_en_i        (en),
    .led_sel_i       (sel),
    .led_r_i         (r),
    .led_g_i         (g),
    .led_b_i         (b),
    .row_valid_o     (row_valid),
    .row_matrix_o    (row_matrix),
    .row_idx_o       (row_idx),
    .row_r_o         (row_r),
    .row_g_o         (row_g),
    .row_b_o         (row_b),
    .len_err_o       (len_err),
    .timeout_err_o   (tmo_err),
    .frame_done_o    (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (row_valid) rv_cnt++;
    if (len_err) le_cnt++;
    if (tmo_err) to_cnt++;
    if (frame_done) begin
      fd_cnt++;
      fd_sel = {row_matrix, row_idx};
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input int k);
    for (int m = 0; m < 4; m++) begin
      r[m] = vr[m][k % 16];
      g[m] = vg[m][k % 16];
      b[m] = vb[m][k % 16];
    end
  endtask

  task automatic shift_bit(input int k);
    tick();
    sclk = 1'b1;
    put_bit(k);
    tick();
    sclk = 1'b0;
  endtask

  // Shift nbits, latch (optionally with the last bit), drop enable.
  task automatic do_row(input int nbits, input bit coin,
                        input logic [4:0] s, output int lat_cyc);
    int n;
    n = coin ? nbits - 1 : nbits;
    for (int k = 0; k < n; k++) shift_bit(k);
    tick();
    lat = 1'b1;
    if (coin) begin
      sclk = 1'b1;
      put_bit(nbits - 1);
    end
    tick();
    sclk = 1'b0;
    lat  = 1'b0;
    en   = 1'b0;
    sel  = s;
    lat_cyc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (row_valid) begin
        lat_cyc = i;
        break;
      end
    end
    if (lat_cyc == 0) chk("row_wait", 0, 1);
    tick();
    en = 1'b1;
    tick();
  endtask

  function automatic logic [15:0] pat(input int s, input int m,
                                      input int c);
    return 16'((s * 16'h0913) ^ (m * 16'h3c11) ^
               (c * 16'h5a5a) ^ 16'h8421);
  endfunction

  task automatic load_pat(input int s);
    for (int m = 0; m < 4; m++) begin
      vr[m] = pat(s, m, 0);
      vg[m] = pat(s, m, 1);
      vb[m] = pat(s, m, 2);
    end
  endtask

  task automatic clr_pat();
    for (int m = 0; m < 4; m++) begin
      vr[m] = '0;
      vg[m] = '0;
      vb[m] = '0;
    end
  endtask

  int rv0, le0, to0, fd0, lc, bad;
  logic ok;

  initial begin
    rst = 1'b1; sclk = 1'b0; lat = 1'b0; en = 1'b1;
    sel = '0; r = '0; g = '0; b = '0;
    clr_pat();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", 32'(row_valid), 0);
    chk("rst_len", 32'(len_err), 0);
    chk("rst_row_r", row_r[31:0], 0);
    chk("rst_sel", 32'({row_matrix, row_idx}), 0);
    tick();
    rst = 1'b0;
    tick();

    // basic row on lane 0 red
    vr[0] = 16'hA5C3;
    rv0 = rv_cnt; le0 = le_cnt;
    do_row(16, 1'b0, 5'b01_011, lc);
    chk("t1_latency", lc, 2);
    chk("t1_rv_cnt", rv_cnt - rv0, 1);
    chk("t1_data", 32'(row_r[15:0]), 32'h0000A5C3);
    chk("t1_lane1", 32'(row_r[31:16]), 0);
    chk("t1_matrix", 32'(row_matrix), 1);
    chk("t1_row", 32'(row_idx), 3);
    chk("t1_len_err", le_cnt - le0, 0);

    // short and long rows
    rv0 = rv_cnt; le0 = le_cnt;
    do_row(15, 1'b0, 5'b00_001, lc);
    chk("t2_short_err", le_cnt - le0, 1);
    chk("t2_short_rv", rv_cnt - rv0, 1);
    vr[0] = 16'h1234;
    rv0 = rv_cnt; le0 = le_cnt;
    do_row(17, 1'b0, 5'b00_010, lc);
    chk("t2_long_err", le_cnt - le0, 1);
    chk("t2_long_rv", rv_cnt - rv0, 1);
    chk("t2_long_data", 32'(row_r[15:0]), 32'h0000091A);

    // enable never arrives
    rv0 = rv_cnt; to0 = to_cnt;
    for (int k = 0; k < 16; k++) shift_bit(k);
    tick();
    lat = 1'b1;
    tick();
    lat = 1'b0;
    repeat (14) tick();
    chk("t3_early_to", to_cnt - to0, 0);
    repeat (6) tick();
    chk("t3_timeout", to_cnt - to0, 1);
    chk("t3_no_row", rv_cnt - rv0, 0);

    // full frame with every lane and colour populated
    rv0 = rv_cnt; fd0 = fd_cnt; bad = 0;
    for (int s = 0; s < 32; s++) begin
      load_pat(s);
      do_row(16, 1'b0, 5'(s), lc);
      ok = ({row_matrix, row_idx} == 5'(s));
      for (int m = 0; m < 4; m++) begin
        if (row_r[m*16 +: 16] != vr[m]) ok = 1'b0;
        if (row_g[m*16 +: 16] != vg[m]) ok = 1'b0;
        if (row_b[m*16 +: 16] != vb[m]) ok = 1'b0;
      end
      if (!ok) bad++;
    end
    chk("t4_rows", rv_cnt - rv0, 32);
    chk("t4_bad_rows", bad, 0);
    chk("t4_frame_done", fd_cnt - fd0, 1);
    chk("t4_fd_sel", 32'(fd_sel), 32'h1F);

    // last bit coincides with latch
    clr_pat();
    vr[0] = 16'h8001;
    vb[3] = 16'hC00F;
    rv0 = rv_cnt; le0 = le_cnt;
    do_row(16, 1'b1, 5'b10_101, lc);
    chk("t5_len_err", le_cnt - le0, 0);
    chk("t5_data_r", 32'(row_r[15:0]), 32'h00008001);
    chk("t5_data_b3", 32'(row_b[63:48]), 32'h0000C00F);

    // reset mid-row then a clean row
    vr[0] = 16'hFFFF;
    for (int k = 0; k < 8; k++) shift_bit(k);
    le0 = le_cnt; to0 = to_cnt;
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("t6_rst_rv", 32'(row_valid), 0);
    tick();
    rst = 1'b0;
    vr[0] = 16'h3C96;
    rv0 = rv_cnt;
    do_row(16, 1'b0, 5'b11_000, lc);
    chk("t6_rv", rv_cnt - rv0, 1);
    chk("t6_data", 32'(row_r[15:0]), 32'h00003C96);
    chk("t6_errs", (le_cnt - le0) + (to_cnt - to0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
